// File: rtl/decod_arb_pkg.sv
// Shared types and helpers for the round-robin decoder arbiter and its
// schedulers.
package decod_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int CHOICE_W = 4;
   localparam int DEC_OUTS = 16;

   // Next index in round-robin order, with an explicit wrap because n need
   // not be a power of two.
   function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
      if (int'(idx) >= n - 1) begin
         return 3'd0;
      end
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first requester at or after ptr,
// found by rotating, priority-encoding and un-rotating.
module rr_picker #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      ptr,
   output logic            any,
   output logic [2:0]      idx
);

   logic [NREQ-1:0] rot;
   logic [2:0]      off;

   always_comb begin
      rot = '0;
      off = '0;
      any = 1'b0;
      idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (j == (int'(ptr) + k) % NREQ) begin
               rot[k] = req[j];
            end
         end
      end
      // Scanning downwards leaves the lowest rotated position as the winner.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = 3'(k);
            any = 1'b1;
         end
      end
      idx = 3'((int'(ptr) + int'(off)) % NREQ);
   end

endmodule

// File: rtl/decod_arbiter.sv
// Round-robin arbiter sharing one 4-to-16 decoder among NREQ requesters;
// latches the winner's code and holds it until release or hold timeout.
module decod_arbiter
   import decod_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*CHOICE_W-1:0] sel,
   input  logic [NREQ-1:0]          rel,
   output logic [NREQ-1:0]          gnt,
   output logic [2:0]               owner,
   output logic [CHOICE_W-1:0]      choice,
   output logic                     choice_vld,
   output logic                     timeout
);

   localparam int TIMER_W = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);

   arb_state_t           state, state_n;
   logic [NREQ-1:0]      gnt_n;
   logic [2:0]           owner_n, ptr, ptr_n;
   logic [CHOICE_W-1:0]  choice_n;
   logic                 vld_n, timeout_n;
   logic [TIMER_W-1:0]   timer, timer_n;

   logic                 pick_any;
   logic [2:0]           pick_idx;
   logic                 owner_req, owner_rel, timer_hit, release_now;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= '0;
         owner      <= '0;
         choice     <= '0;
         choice_vld <= 1'b0;
         timeout    <= 1'b0;
         ptr        <= '0;
         timer      <= '0;
      end else begin
         state      <= state_n;
         gnt        <= gnt_n;
         owner      <= owner_n;
         choice     <= choice_n;
         choice_vld <= vld_n;
         timeout    <= timeout_n;
         ptr        <= ptr_n;
         timer      <= timer_n;
      end
   end

   always_comb begin
      owner_req = 1'b0;
      owner_rel = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (int'(owner) == i) begin
            owner_req = req[i];
            owner_rel = rel[i];
         end
      end
      timer_hit   = (MAX_HOLD != 0) && (int'(timer) == MAX_HOLD - 1);
      release_now = owner_rel || !owner_req || timer_hit;
   end

   // Every release passes through IDLE, which guarantees a dead cycle
   // between grants and a clean decoder switchover.
   always_comb begin
      state_n   = state;
      gnt_n     = gnt;
      owner_n   = owner;
      choice_n  = choice;
      vld_n     = choice_vld;
      timeout_n = 1'b0;
      ptr_n     = ptr;
      timer_n   = timer;
      case (state)
         IDLE: begin
            gnt_n = '0;
            vld_n = 1'b0;
            if (pick_any) begin
               for (int i = 0; i < NREQ; i++) begin
                  gnt_n[i] = (int'(pick_idx) == i);
                  if (int'(pick_idx) == i) begin
                     choice_n = sel[i*CHOICE_W +: CHOICE_W];
                  end
               end
               owner_n = pick_idx;
               vld_n   = 1'b1;
               timer_n = '0;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (release_now) begin
               gnt_n     = '0;
               vld_n     = 1'b0;
               ptr_n     = rr_next(owner, NREQ);
               timeout_n = timer_hit && !owner_rel && owner_req;
               state_n   = IDLE;
            end else if (timer != {TIMER_W{1'b1}}) begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            vld_n   = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/decod_arbiter.md
Name: decod_arbiter

Overview:
- Shares one 4-to-16 one-hot decoder among NREQ requesters.
- Each requester presents a 4-bit select code. The arbiter grants one requester at a time, round-robin.
- While a grant is held, the arbiter latches the winner's code onto the decoder's 4-bit choice input and asserts a valid/enable.
- Sits between requester logic (FSMs, switches) and the shared decoder. The decoder's one-hot output lines drive the shared row/LED/register resource.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_HOLD, 8, maximum BUSY cycles per grant before forced release; 0 disables timeout
CHOICE_W, 4, select code width (decoder input width; fixed 4 for the 16-way decoder)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  request per requester, level
sel  in  NREQ*CHOICE_W  select code per requester; requester i uses bits [i*4+3:i*4]
rel  in  NREQ  release pulse per requester
gnt  out  NREQ  one-hot grant, registered
owner  out  3  index of current/last grantee
choice  out  CHOICE_W  latched code to decoder choice input
choice_vld  out  1  decoder enable; high only while BUSY
timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_n low, asynchronous; takes effect immediately, any state): state=IDLE, gnt=0, owner=0, choice=0, choice_vld=0, timeout=0, ptr=0, timer=0.
- Reset mid-grant drops gnt and choice_vld at once, with no release handshake. After reset the pointer starts again at requester 0.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE:
  - If any req bit is high, the winner is the first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - Next edge: gnt[i]=1, owner=i, choice=sel[i], choice_vld=1, timer=0, state=BUSY.
  - Latency is one cycle from req sampled high to gnt high.
  - If no req, stay IDLE with outputs 0 (choice holds its last value).
- State BUSY:
  - choice stays frozen at the latched code; sel changes are ignored.
  - timer increments each BUSY cycle, saturating.
  - Release condition (any one): rel[owner]=1, req[owner]=0, or (MAX_HOLD!=0 and timer==MAX_HOLD-1).
  - On release, next edge: gnt=0, choice_vld=0, ptr=(owner+1) mod NREQ, state=IDLE.
  - timeout=1 for exactly that one cycle, and only if the release was the timer-only cause. If rel or req-drop coincides with timeout, timeout=0.
- Dead cycle: every release forces at least one IDLE cycle, so choice_vld=0 for at least 1 cycle between grants. This guarantees a glitch-free decoder switchover.
  - Back-to-back sequence: release seen in cycle N -> gnt=0 in N+1 -> next gnt earliest in N+2.
- rel[j] or sel[j] from a non-owner is ignored. rel while IDLE is ignored.
- Sole requester re-requesting after release regains the grant after the one dead cycle; the pointer advance has no effect on it.
- gnt is always one-hot or zero. choice_vld == |gnt at all times.
- req high in the same cycle as a release is not considered until the IDLE cycle.
- Width rules:
  - ptr and owner are 3 bits and wrap mod NREQ (explicit compare-and-reset, not a power-of-2 wrap).
  - timer width is $clog2(MAX_HOLD+1), minimum 1.

Decomposition:
- Package decod_arb_pkg:
  - state enum {IDLE, BUSY};
  - CHOICE_W=4, DEC_OUTS=16;
  - a function returning the round-robin next index.
- Sub-module rr_picker: purely combinational.
  - Inputs: req[NREQ] and ptr.
  - Outputs: any, idx[2:0].
  - Implementation: rotate, priority-encode, un-rotate.
  - Reused by future schedulers.
- The FSM, timer and output registers live in decod_arbiter.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, choice_vld=0, choice=0. Release rst_n, req[0..3]=1 -> gnt=4'b0001 one cycle later, choice=sel[0].
- Round-robin: sel={4'd12,4'd9,4'd5,4'd3}, all req high, each owner pulses rel after 2 BUSY cycles -> grant order 0,1,2,3,0. choice sequence 3,5,9,12,3, with one choice_vld=0 cycle between each.
- Timeout: only req[2]=1 with sel[2]=4'd7 held forever, MAX_HOLD=8 -> gnt[2] high exactly 8 cycles, timeout pulses once, 1 dead cycle, then re-grant to 2.
- Code freeze: granted requester 1 with sel[1]=4'd4; change sel[1] to 4'd15 mid-grant -> choice stays 4. The next grant to requester 1 latches 15.
- Simultaneous/ignored: rel[3] pulsed while owner=0 -> no effect. rel[0] in the same cycle as the timer limit -> release with timeout=0.
- Async reset mid-BUSY: assert rst_n low between clock edges while gnt[1]=1 -> gnt, choice_vld and choice drop to 0 immediately, before the next edge. After release, arbitration restarts from ptr=0.
